// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcode nibbles, default halt word and FSM state encoding
// for the ROM fetch sequencer.
package fetch_pkg;
    localparam int DATA_WIDTH = 16;
    localparam logic [3:0] RAM_OP    = 4'h4;
    localparam logic [3:0] ROM_OP    = 4'h3;
    localparam logic [3:0] REG_OP    = 4'h9;
    localparam logic [3:0] RAM_WRITE = 4'h1;
    localparam logic [3:0] RAM_READ  = 4'h2;
    localparam logic [15:0] HALT_OPCODE = 16'hFFFF;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_ARG,
        S_CAPT_ARG,
        S_ISSUE,
        S_HALTED
    } fetch_state_t;
endpackage

// File: rtl/fetch_op_decode.sv
// fetch_op_decode: classifies an opcode's upper byte as a RAM read or write instruction.
module fetch_op_decode
    import fetch_pkg::*;
(
    input  logic [7:0] opcode_hi,
    output logic       is_read,
    output logic       is_write
);
    logic [3:0] sel;
    logic [3:0] op;
    always_comb begin
        sel      = opcode_hi[7:4];
        op       = opcode_hi[3:0];
        is_write = (op == RAM_WRITE) && (sel == RAM_OP || sel == ROM_OP || sel == REG_OP);
        is_read  = (op == RAM_READ) && (sel == RAM_OP || sel == REG_OP);
    end
endmodule

// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer: fetches opcode/operand pairs from a synchronous ROM and issues them
// with a valid/ready handshake; optional instr_count output under FETCH_INSTR_COUNT_EN.
module rom_fetch_sequencer #(
    parameter int DATA_WIDTH = fetch_pkg::DATA_WIDTH,
    parameter int ROM_ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ROM_ADDR_WIDTH-1:0] start_addr,
    output logic                      rom_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_data,
    output logic [DATA_WIDTH-1:0]     opcode,
    output logic [DATA_WIDTH-1:0]     operand,
    output logic                      exec_valid,
    input  logic                      exec_ready,
    output logic                      read_enable,
    output logic                      write_enable,
    output logic                      busy,
    output logic                      halted,
    output logic [ROM_ADDR_WIDTH-1:0] pc
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [15:0]               instr_count
`endif
);
    import fetch_pkg::*;

    fetch_state_t state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d, operand_q, operand_d;
    logic is_read, is_write, xfer, start_ok;

    fetch_op_decode u_decode (
        .opcode_hi(opcode_q[15:8]),
        .is_read  (is_read),
        .is_write (is_write)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        start_ok  = (state_q == S_IDLE || state_q == S_HALTED) && start;
        xfer      = (state_q == S_ISSUE) && exec_ready;
        case (state_q)
            S_IDLE, S_HALTED: begin
                pc_d    = start_ok ? start_addr : pc_q;
                state_d = start_ok ? S_FETCH_OP : state_q;
            end
            S_FETCH_OP:  state_d = S_FETCH_ARG;
            S_FETCH_ARG: begin
                opcode_d = rom_data;
                state_d  = (rom_data == HALT_OPCODE) ? S_HALTED : S_CAPT_ARG;
            end
            S_CAPT_ARG: begin
                operand_d = rom_data;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                pc_d    = xfer ? pc_q + ROM_ADDR_WIDTH'(2) : pc_q;
                state_d = xfer ? S_FETCH_OP : S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    // The operand word sits at pc+1 and wraps naturally at the top of the ROM.
    always_comb begin
        rom_en       = (state_q == S_FETCH_OP) || (state_q == S_FETCH_ARG);
        rom_addr     = (state_q == S_FETCH_OP) ? pc_q :
                       (state_q == S_FETCH_ARG) ? pc_q + ROM_ADDR_WIDTH'(1) : '0;
        exec_valid   = state_q == S_ISSUE;
        read_enable  = xfer && is_read;
        write_enable = xfer && is_write;
        busy         = !(state_q == S_IDLE || state_q == S_HALTED);
        halted       = state_q == S_HALTED;
        opcode       = opcode_q;
        operand      = operand_q;
        pc           = pc_q;
    end

`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] count_q, count_d;
    always_comb begin
        count_d = start_ok ? 16'h0 :
                  (xfer && count_q != 16'hFFFF) ? count_q + 16'h1 : count_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else count_q <= count_d;
    end
    assign instr_count = count_q;
`endif
endmodule
